bank_port_arbiter: RTL
======================

// Module: bank_port_arbiter
// PURPOSE
//  Shares the 128x128-bit bank's write port and read port between NUM_REQ requesters.
//  Each port has its own round-robin arbiter. Bank control signals are registered.
//  Read data is returned to the requester that issued the read, tagged with its ID.
//  Sits between the compute clients and the bank instance. Drives vsi_input*/vsi_output* directly.
// PARAMETERS
//  NUM_REQ       4    number of requesters (2..8)
//  DATA_W        128  bank word width
//  ADDR_W        7    bank address width
//  READ_LATENCY  1    cycles from bank sampling vsi_outputAddr to valid vsi_outputData (1..4)
// PORTS
//  vsi_clk               in   1               clock; all state updates on the rising edge
//  vsi_reset             in   1               asynchronous reset, active-high
//  wr_valid              in   NUM_REQ         per-requester write request
//  wr_ready              out  NUM_REQ         write grant, one-hot or zero
//  wr_addr               in   NUM_REQ*ADDR_W  per-requester write address; slice i belongs to requester i
//  wr_data               in   NUM_REQ*DATA_W  per-requester write data
//  rd_valid              in   NUM_REQ         per-requester read request
//  rd_ready              out  NUM_REQ         read grant, one-hot or zero
//  rd_addr               in   NUM_REQ*ADDR_W  per-requester read address
//  rsp_valid             out  1               read response valid
//  rsp_id                out  $clog2(NUM_REQ) requester the response belongs to
//  rsp_data              out  DATA_W          read response data
//  vsi_inputChipSelect   out  1               bank write enable (registered)
//  vsi_inputAddr         out  ADDR_W          bank write address (registered)
//  vsi_inputData         out  DATA_W          bank write data (registered)
//  vsi_outputChipSelect  out  1               bank read enable (registered)
//  vsi_outputAddr        out  ADDR_W          bank read address (registered)
//  vsi_outputData        in   DATA_W          bank read data
// BEHAVIOUR
//  Reset values
//   - On vsi_reset, all outputs go to 0 immediately (asynchronous).
//   - Both RR pointers go to 0, and the read-tag pipeline is cleared.
//   - Reads in flight when reset asserts are dropped; no rsp_valid is issued for them.
//  Handshake
//   - A transfer occurs when valid[i] && ready[i] at a rising edge.
//   - ready is combinational from valid, the RR pointer and the hazard check.
//   - Requesters hold valid, addr and data stable until ready is seen.
//  Round-robin
//   - Per port: grant the first requester with valid set, searching from ptr upward with wrap NUM_REQ-1 -> 0.
//   - On a grant to k, ptr <= (k+1) mod NUM_REQ. With no grant, ptr holds.
//  Bank drive
//   - A write accepted in cycle t gives, in cycle t+1: vsi_inputChipSelect=1, Addr and Data from the winner.
//   - A read accepted in cycle t gives, in cycle t+1: vsi_outputChipSelect=1, vsi_outputAddr from the winner.
//   - Chip selects are 0 in any cycle with no accepted transfer. Addr and Data hold their last values.
//   - Throughput: one write plus one read per cycle.
//  Read-after-write hazard
//   - If both ports have a winner in the same cycle and the write address equals the read address:
//     the write is granted, all rd_ready bits are 0, and rd_ptr holds.
//   - The read wins the following cycle, so it always returns the new data.
//  Response
//   - A shift register of depth READ_LATENCY carries {valid, id}.
//   - For a read accepted in cycle t: rsp_valid=1 and rsp_id=id in cycle t+1+READ_LATENCY.
//   - rsp_data is vsi_outputData passed through combinationally while rsp_valid is high.
//   - There is no back-pressure on responses; the consumer must always accept.
// STRUCTURE
//  bank_ctrl_pkg
//   - Holds DATA_W/ADDR_W defaults, the ID width function, and the typedef rd_tag_t {logic valid; id}.
//  rr_arbiter
//   - Sub-module with parameter N; inputs req[N] and advance; outputs grant[N] and gidx.
//   - Holds its pointer internally.
//   - Instantiated twice: write port and read port. advance is driven by the handshake.
// TESTING
//  1. Reset, then requester 0 writes addr 5 data 0xA5..A5 -> vsi_inputChipSelect=1, Addr=5 one cycle after the handshake.
//  2. All 4 wr_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3; wr_ready is one-hot every cycle.
//  3. Same cycle: req1 writes addr 9 = 0x1234, req2 reads addr 9 -> read granted one cycle later; rsp_id=2, rsp_data=0x1234.
//  4. Back-to-back reads from req3 at addr 0..9 -> 10 consecutive rsp_valid cycles, in order, all with rsp_id=3.
//  5. vsi_reset pulsed while 2 reads are in flight -> no rsp_valid afterwards; chip selects 0 within the reset cycle.
//  6. rd_valid only on req2 while rd_ptr=3 -> grant to req2 wraps correctly; ptr becomes 3.

Source files
------------

// File: rtl/bank_ctrl_pkg.sv
// Shared constants and types for the bank port arbiter.
// Includes the bank geometry defaults, the requester ID width helper and the read-tag record.
package bank_ctrl_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int ADDR_W_DEF = 7;
  // Wide enough for the largest supported requester count (8)
  localparam int MAX_ID_W   = 3;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer, wrapping around.
// The pointer moves past the winner only when the caller reports that the grant was used.
module rr_arbiter
  import bank_ctrl_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = id_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gidx
);

  logic [IW-1:0] ptr_reg;
  logic          found;
  int            cand;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr_reg) + off;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gidx        = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/bank_port_arbiter.sv
// Shares one bank write port and one bank read port among NUM_REQ requesters.
// Bank controls are registered; read responses come back tagged with the issuing requester.
module bank_port_arbiter
  import bank_ctrl_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_W       = DATA_W_DEF,
  parameter  int ADDR_W       = ADDR_W_DEF,
  parameter  int READ_LATENCY = 1,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                      vsi_clk,
  input  logic                      vsi_reset,
  input  logic [NUM_REQ-1:0]        wr_valid,
  output logic [NUM_REQ-1:0]        wr_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  input  logic [NUM_REQ-1:0]        rd_valid,
  output logic [NUM_REQ-1:0]        rd_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      vsi_inputChipSelect,
  output logic [ADDR_W-1:0]         vsi_inputAddr,
  output logic [DATA_W-1:0]         vsi_inputData,
  output logic                      vsi_outputChipSelect,
  output logic [ADDR_W-1:0]         vsi_outputAddr,
  input  logic [DATA_W-1:0]         vsi_outputData
);

  logic [NUM_REQ-1:0][ADDR_W-1:0] wr_addr_arr;
  logic [NUM_REQ-1:0][DATA_W-1:0] wr_data_arr;
  logic [NUM_REQ-1:0][ADDR_W-1:0] rd_addr_arr;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign wr_addr_arr[gi] = wr_addr[gi*ADDR_W +: ADDR_W];
      assign wr_data_arr[gi] = wr_data[gi*DATA_W +: DATA_W];
      assign rd_addr_arr[gi] = rd_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  logic [NUM_REQ-1:0] wr_grant;
  logic [NUM_REQ-1:0] rd_grant;
  logic [ID_W-1:0]    wr_gidx;
  logic [ID_W-1:0]    rd_gidx;
  logic               wr_fire;
  logic               rd_fire;
  logic               hazard;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk     (vsi_clk),
    .rst     (vsi_reset),
    .req     (wr_valid),
    .advance (wr_fire),
    .grant   (wr_grant),
    .gidx    (wr_gidx)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk     (vsi_clk),
    .rst     (vsi_reset),
    .req     (rd_valid),
    .advance (rd_fire),
    .grant   (rd_grant),
    .gidx    (rd_gidx)
  );

  // A read colliding with a same-cycle write to the same word waits one cycle,
  // so the bank has committed the new data before the read samples it.
  assign hazard   = (|wr_grant) && (|rd_grant) && (wr_addr_arr[wr_gidx] == rd_addr_arr[rd_gidx]);
  assign wr_ready = wr_grant;
  assign rd_ready = hazard ? '0 : rd_grant;
  assign wr_fire  = |wr_grant;
  assign rd_fire  = (|rd_grant) && !hazard;

  logic [MAX_ID_W-1:0] rd_id_reg;

  always_ff @(posedge vsi_clk or posedge vsi_reset) begin
    if (vsi_reset) begin
      vsi_inputChipSelect  <= 1'b0;
      vsi_inputAddr        <= '0;
      vsi_inputData        <= '0;
      vsi_outputChipSelect <= 1'b0;
      vsi_outputAddr       <= '0;
      rd_id_reg            <= '0;
    end else begin
      vsi_inputChipSelect  <= wr_fire;
      vsi_outputChipSelect <= rd_fire;
      if (wr_fire) begin
        vsi_inputAddr <= wr_addr_arr[wr_gidx];
        vsi_inputData <= wr_data_arr[wr_gidx];
      end
      if (rd_fire) begin
        vsi_outputAddr <= rd_addr_arr[rd_gidx];
        rd_id_reg      <= MAX_ID_W'(rd_gidx);
      end
    end
  end

  // Tag pipeline tracks the bank's read latency behind the registered read strobe
  rd_tag_t tag_reg [READ_LATENCY];

  always_ff @(posedge vsi_clk or posedge vsi_reset) begin
    if (vsi_reset) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_reg[i] <= '0;
    end else begin
      tag_reg[0] <= '{valid: vsi_outputChipSelect, id: rd_id_reg};
      for (int i = 1; i < READ_LATENCY; i++) tag_reg[i] <= tag_reg[i-1];
    end
  end

  logic [MAX_ID_W-1:0] tag_id_full;
  logic                unused_tag_id;

  assign tag_id_full   = tag_reg[READ_LATENCY-1].id;
  assign unused_tag_id = ^tag_id_full;
  assign rsp_valid     = tag_reg[READ_LATENCY-1].valid;
  assign rsp_id        = tag_id_full[ID_W-1:0];
  assign rsp_data      = rsp_valid ? vsi_outputData : '0;

endmodule
